// File: rtl/pb_conditioner.sv
// Pushbutton conditioning front end for the tone-generator core: two-flop
// synchronizer, per-button debounce, rising-edge pulses, note priority decode, mode/octave state.
module pb_conditioner #(
  parameter int NUM_PB   = 15,
  parameter int DB_LIMIT = 10000
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [NUM_PB-1:0] pb_raw,
  output logic [NUM_PB-1:0] pb_clean,
  output logic [NUM_PB-1:0] pb_rise,
  output logic              note_valid,
  output logic [3:0]        note_idx,
  output logic [1:0]        mode,
  output logic              octave
);

  localparam int CNT_W = $clog2(DB_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_LIMIT - 1);

  logic [NUM_PB-1:0] sync1_q, sync1_d;
  logic [NUM_PB-1:0] sync2_q, sync2_d;
  logic [NUM_PB-1:0] clean_q, clean_d;
  logic [NUM_PB-1:0] clean_prev_q, clean_prev_d;
  logic [CNT_W-1:0]  cnt_q [NUM_PB];
  logic [CNT_W-1:0]  cnt_d [NUM_PB];
  logic              note_valid_q, note_valid_d;
  logic [3:0]        note_idx_q, note_idx_d;
  logic [1:0]        mode_q, mode_d;
  logic              octave_q, octave_d;
  logic [NUM_PB-1:0] rise;

  assign rise = clean_q & ~clean_prev_q;

  always_comb begin
    sync1_d      = pb_raw;
    sync2_d      = sync1_q;
    clean_prev_d = clean_q;
    clean_d      = clean_q;
    for (int i = 0; i < NUM_PB; i++) begin
      cnt_d[i] = '0;
      // Any agreement with the accepted level restarts the stability count.
      if (sync2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          clean_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    note_valid_d = |clean_q[12:0];
    note_idx_d   = 4'd0;
    // Ascending scan so the highest held key overwrites lower ones.
    for (int i = 0; i < 13; i++) begin
      if (clean_q[i]) begin
        note_idx_d = 4'(i);
      end
    end
    mode_d   = mode_q + (rise[13] ? 2'd1 : 2'd0);
    octave_d = octave_q ^ rise[14];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      clean_q      <= '0;
      clean_prev_q <= '0;
      for (int i = 0; i < NUM_PB; i++) begin
        cnt_q[i] <= '0;
      end
      note_valid_q <= 1'b0;
      note_idx_q   <= 4'd0;
      mode_q       <= 2'd0;
      octave_q     <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      clean_q      <= clean_d;
      clean_prev_q <= clean_prev_d;
      for (int i = 0; i < NUM_PB; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      note_valid_q <= note_valid_d;
      note_idx_q   <= note_idx_d;
      mode_q       <= mode_d;
      octave_q     <= octave_d;
    end
  end

  assign pb_clean   = clean_q;
  assign pb_rise    = rise;
  assign note_valid = note_valid_q;
  assign note_idx   = note_idx_q;
  assign mode       = mode_q;
  assign octave     = octave_q;

endmodule

// File: doc/pb_conditioner.md
# pb_conditioner

Input conditioning stage that sits directly upstream of the tone-generator core and feeds its `pb` bus. It synchronizes the 15 raw breakout-board pushbuttons, debounces each one independently, produces one-cycle rising-edge pulses, and decodes the clean buttons into a prioritized note index plus the 2-bit mode and octave state. All outputs are registered or derived from registered state, so the core never sees a metastable or bouncing input.

## Interface
- `NUM_PB`, 15, number of pushbuttons. Fixed at 15; other values are unsupported.
- `DB_LIMIT`, 10000, consecutive stable cycles required to accept a level change. Legal range is 1 to 65535.
- `CNT_W`, `$clog2(DB_LIMIT+1)`, width of each debounce counter. This is a derived localparam.

Ports:
- `clk`  in  1  system clock.
- `n_rst`  in  1  asynchronous active-low reset.
- `pb_raw`  in  15  raw pushbuttons, active high. Bits 12:0 are note keys C..C'. Bit 13 is mode-cycle. Bit 14 is octave-toggle.
- `pb_clean`  out  15  debounced button levels.
- `pb_rise`  out  15  one-cycle pulse per button on a debounced 0→1 transition.
- `note_valid`  out  1  high when at least one of `pb_clean[12:0]` is high.
- `note_idx`  out  4  index of the highest-numbered held note key. Reads 0 when `note_valid` is 0.
- `mode`  out  2  current mode, wrapping counter.
- `octave`  out  1  octave select, toggle.

## Operation
- **Synchronizer.** Two flops per bit: `pb_raw` → `sync1` → `sync2`. No logic sits between the two flops.
- **Debounce counters.** Each bit has its own counter `cnt[i]`.
  - If `sync2[i] == pb_clean[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == DB_LIMIT-1`: `pb_clean[i] <= sync2[i]` and `cnt[i] <= 0`.
  - Else: `cnt[i] <= cnt[i]+1`.
  - A mismatch shorter than `DB_LIMIT` consecutive cycles clears the counter and never changes `pb_clean`.
- **Edge detect.** A registered copy `clean_d <= pb_clean` is kept. `pb_rise = pb_clean & ~clean_d`. The pulse is high only in the first cycle `pb_clean[i]` reads 1. Falling edges produce no pulse.
- **Note decode.** Registered from `pb_clean[12:0]`.
  - `note_valid <= |pb_clean[12:0]`.
  - `note_idx <=` highest set bit index, or 0 if none. Highest index wins.
- **Mode.** On `pb_rise[13]`, `mode <= mode+1`, wrapping 3→0 (2-bit modulo).
- **Octave.** On `pb_rise[14]`, `octave <= ~octave`.
- **Simultaneous events.** `pb_rise[13]` and `pb_rise[14]` in the same cycle update both mode and octave. Note keys never affect mode or octave.
- **Reset values.**
  - `sync1`, `sync2`, `cnt`, `pb_clean`, `clean_d`: 0.
  - `pb_rise`: 0.
  - `note_valid`, `note_idx`, `mode`, `octave`: 0.
- **Reset mid-operation.** Asserting `n_rst` clears everything immediately, regardless of `clk`. A button held through reset release is treated as a new press: `pb_clean` rises after the normal latency and generates a `pb_rise`. A held mode button therefore advances mode to 1.

## Timing
- **Press/release latency.** A `pb_raw` change first captured into `sync1` at edge E0 updates `pb_clean` at edge E0+1+`DB_LIMIT`, provided `pb_raw` stays stable throughout.
- **Edge pulse.** `pb_rise` is asserted in the cycle after that edge, i.e. the same cycle `pb_clean` first shows 1. It lasts exactly one cycle.
- **Note outputs.** `note_valid` and `note_idx` lag `pb_clean` by 1 cycle.
- **Mode/octave outputs.** `mode` and `octave` update at the edge ending the `pb_rise` cycle, so they lag `pb_clean` by 1 cycle.
- **Throughput.** No handshake and no backpressure. Outputs are valid every cycle.
- **Minimum `DB_LIMIT`.** With `DB_LIMIT=1`, the debounce filter passes any level lasting at least 1 synchronized cycle.

## Test plan
All scenarios use `DB_LIMIT=4`.
- **Reset values.** Assert `n_rst`=0 with `pb_raw`=15'h7FFF. All outputs must read 0 during reset. After release, `pb_clean` must reach 15'h7FFF 5 cycles after first capture, `mode` must be 1 and `octave` must be 1.
- **Clean press.** Set `pb_raw[5]` high before edge E0. `pb_clean[5]` must rise at E0+5. `pb_rise[5]` must be high for exactly 1 cycle. One cycle later `note_valid`=1 and `note_idx`=5.
- **Glitch rejection and release.**
  - Pulse `pb_raw[3]` high for 3 cycles, then low: `pb_clean`, `pb_rise` and `note_valid` stay 0.
  - Hold `pb_raw[3]` high for 20 cycles, then release: `pb_clean[3]` falls 5 cycles after release and no pulse is generated.
- **Priority.** Hold bits 2, 9 and 12 high: `note_idx` must read 12. Release bit 12: `note_idx` must read 9 after debounce+1 cycles.
- **Mode wrap.** Give 5 debounced presses of `pb[13]`: `mode` must step 1, 2, 3, 0, 1. `octave` must stay 0.
- **Simultaneous press and reset mid-count.**
  - Press `pb[13]` and `pb[14]` together: `mode` and `octave` must update in the same cycle.
  - Assert `n_rst` while a counter is at 2: all state must clear immediately.
